// File: rtl/rvfi_dmem_pkg.sv
// Shared types and helpers for the RVFI data-memory consistency checker.
package rvfi_dmem_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned NB       = XLEN_DEF / 8;
  localparam int unsigned LANE_W   = $clog2(NB);

  typedef struct packed {
    logic [NB-1:0]       written;
    logic [XLEN_DEF-1:0] data;
  } entry_t;

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 64; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/rvfi_dmem_shadow_entry.sv
// One shadowed word: byte data plus written bits, with the per-channel chained view
// and per-lane check/mismatch vectors. Optional assertions under RISCV_FORMAL_DMEM_ASSERT_EN.
module rvfi_dmem_shadow_entry
  import rvfi_dmem_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NRET = 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [XLEN-1:0]            track_addr,
  input  logic [NRET-1:0]            valid,
  input  logic [NRET*XLEN-1:0]       mem_addr,
  input  logic [NRET*(XLEN/8)-1:0]   rmask,
  input  logic [NRET*(XLEN/8)-1:0]   wmask,
  input  logic [NRET*XLEN-1:0]       rdata,
  input  logic [NRET*XLEN-1:0]       wdata,
  output logic [NRET*(XLEN/8)-1:0]   check,
  output logic [NRET*(XLEN/8)-1:0]   mism
);

  localparam int unsigned LANES = XLEN / 8;
  localparam int unsigned LW    = $clog2(LANES);

  typedef struct packed {
    logic [LANES-1:0] written;
    logic [XLEN-1:0]  data;
  } shadow_t;

  shadow_t cur;
  shadow_t view;
  logic    hit;

  // Each channel checks against the view left by lower channels, then applies its own
  // write, so a same-channel AMO sees the old bytes.
  always_comb begin
    view  = cur;
    check = '0;
    mism  = '0;
    hit   = 1'b0;
    for (int unsigned c = 0; c < NRET; c++) begin
      hit = valid[c] && (mem_addr[c*XLEN+LW +: XLEN-LW] == track_addr[XLEN-1:LW]);
      for (int unsigned i = 0; i < LANES; i++) begin
        if (hit && rmask[c*LANES+i] && view.written[i]) begin
          check[c*LANES+i] = 1'b1;
          mism[c*LANES+i]  = (view.data[i*8 +: 8] != rdata[c*XLEN+i*8 +: 8]);
        end
      end
      for (int unsigned i = 0; i < LANES; i++) begin
        if (hit && wmask[c*LANES+i]) begin
          view.written[i]      = 1'b1;
          view.data[i*8 +: 8]  = wdata[c*XLEN+i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cur <= '0;
    else         cur <= view;
  end

`ifdef RISCV_FORMAL_DMEM_ASSERT_EN
  always_ff @(posedge clk) begin
    if (resetn) begin
      for (int unsigned k = 0; k < NRET*LANES; k++) begin
        if (check[k]) assert (!mism[k]);
      end
    end
  end
`endif

endmodule

// File: rtl/rvfi_dmem_multi_check.sv
// Multi-word, multi-channel RVFI data-memory consistency checker with sticky error capture.
// Define RISCV_FORMAL_DMEM_ASSERT_EN to add immediate assertions on every byte check.
module rvfi_dmem_multi_check
  import rvfi_dmem_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NRET  = 1,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [DEPTH*XLEN-1:0]          track_addr,
  input  logic [NRET-1:0]                rvfi_valid,
  input  logic [NRET*64-1:0]             rvfi_order,
  input  logic [NRET*XLEN-1:0]           rvfi_mem_addr,
  input  logic [NRET*(XLEN/8)-1:0]       rvfi_mem_rmask,
  input  logic [NRET*(XLEN/8)-1:0]       rvfi_mem_wmask,
  input  logic [NRET*XLEN-1:0]           rvfi_mem_rdata,
  input  logic [NRET*XLEN-1:0]           rvfi_mem_wdata,
  output logic                           err,
  output logic [63:0]                    err_order,
  output logic [$clog2(NRET):0]          err_chan,
  output logic [$clog2(XLEN/8):0]        err_byte,
  output logic [CNTW-1:0]                check_cnt
);

  localparam int unsigned LANES = XLEN / 8;
  localparam int unsigned CHW   = $clog2(NRET) + 1;
  localparam int unsigned BW    = $clog2(LANES) + 1;
  localparam logic [CNTW+31:0] CNT_MAX = {{32{1'b0}}, {CNTW{1'b1}}};

  logic [NRET*LANES-1:0] chk_e  [DEPTH];
  logic [NRET*LANES-1:0] mism_e [DEPTH];

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    rvfi_dmem_shadow_entry #(.XLEN(XLEN), .NRET(NRET)) u_entry (
      .clk        (clk),
      .resetn     (resetn),
      .track_addr (track_addr[e*XLEN +: XLEN]),
      .valid      (rvfi_valid),
      .mem_addr   (rvfi_mem_addr),
      .rmask      (rvfi_mem_rmask),
      .wmask      (rvfi_mem_wmask),
      .rdata      (rvfi_mem_rdata),
      .wdata      (rvfi_mem_wdata),
      .check      (chk_e[e]),
      .mism       (mism_e[e])
    );
  end

  logic [NRET*LANES-1:0] mism_all;
  int unsigned           add;
  logic                  found;
  logic [CHW-1:0]        first_chan;
  logic [BW-1:0]         first_byte;
  logic [63:0]           first_order;
  logic [CNTW+31:0]      sum;
  logic [CNTW-1:0]       cnt_next;

  always_comb begin
    mism_all = '0;
    add      = 0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      mism_all |= mism_e[e];
      for (int unsigned c = 0; c < NRET; c++)
        add += popcount(64'(chk_e[e][c*LANES +: LANES]));
    end
  end

  // Channel-major scan picks the lowest channel first, then its lowest lane.
  always_comb begin
    found       = 1'b0;
    first_chan  = '0;
    first_byte  = '0;
    first_order = '0;
    for (int unsigned c = 0; c < NRET; c++) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (!found && mism_all[c*LANES+i]) begin
          found       = 1'b1;
          first_chan  = CHW'(c);
          first_byte  = BW'(i);
          first_order = rvfi_order[c*64 +: 64];
        end
      end
    end
  end

  always_comb begin
    sum      = (CNTW+32)'(check_cnt) + (CNTW+32)'(add);
    cnt_next = (sum > CNT_MAX) ? '1 : sum[CNTW-1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err       <= 1'b0;
      err_order <= '0;
      err_chan  <= '0;
      err_byte  <= '0;
      check_cnt <= '0;
    end else begin
      if (found && !err) begin
        err       <= 1'b1;
        err_order <= first_order;
        err_chan  <= first_chan;
        err_byte  <= first_byte;
      end
      check_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_rvfi_dmem_multi_check.sv
// Self-checking bench: directed scenarios plus randomized traffic against a byte-addressed reference model.
module tb_rvfi_dmem_multi_check;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int unsigned tracked [4] = '{32'h100, 32'h200, 32'h300, 32'h400};

  logic [127:0] track_addr;
  logic [1:0]   valid;
  logic [127:0] order;
  logic [63:0]  addr, rdata, wdata;
  logic [7:0]   rmask, wmask;

  logic        err, s_err;
  logic [63:0] err_order, s_err_order;
  logic [1:0]  err_chan, s_err_chan;
  logic [2:0]  err_byte, s_err_byte;
  logic [15:0] cnt;
  logic [3:0]  s_cnt;

  assign track_addr = {tracked[3], tracked[2], tracked[1], tracked[0]};

  rvfi_dmem_multi_check #(.XLEN(32), .NRET(2), .DEPTH(4), .CNTW(16)) dut (
    .clk(clk), .resetn(resetn), .track_addr(track_addr),
    .rvfi_valid(valid), .rvfi_order(order), .rvfi_mem_addr(addr),
    .rvfi_mem_rmask(rmask), .rvfi_mem_wmask(wmask),
    .rvfi_mem_rdata(rdata), .rvfi_mem_wdata(wdata),
    .err(err), .err_order(err_order), .err_chan(err_chan),
    .err_byte(err_byte), .check_cnt(cnt)
  );

  rvfi_dmem_multi_check #(.XLEN(32), .NRET(2), .DEPTH(4), .CNTW(4)) dut_small (
    .clk(clk), .resetn(resetn), .track_addr(track_addr),
    .rvfi_valid(valid), .rvfi_order(order), .rvfi_mem_addr(addr),
    .rvfi_mem_rmask(rmask), .rvfi_mem_wmask(wmask),
    .rvfi_mem_rdata(rdata), .rvfi_mem_wdata(wdata),
    .err(s_err), .err_order(s_err_order), .err_chan(s_err_chan),
    .err_byte(s_err_byte), .check_cnt(s_cnt)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: byte-addressed memory of tracked bytes, sticky first-error capture.
  logic [7:0]  m_mem [int unsigned];
  int unsigned m_cnt;
  bit          m_err;
  logic [63:0] m_order;
  int unsigned m_chan, m_byte;

  function automatic int unsigned mult(input logic [31:0] a);
    int unsigned m = 0;
    for (int e = 0; e < 4; e++) if ((tracked[e] >> 2) == (a >> 2)) m++;
    return m;
  endfunction

  task automatic model_reset();
    m_mem.delete();
    m_cnt = 0; m_err = 0; m_order = '0; m_chan = 0; m_byte = 0;
  endtask

  task automatic clear_bus();
    valid = '0; order = '0; addr = '0; rdata = '0; wdata = '0; rmask = '0; wmask = '0;
  endtask

  task automatic set_ch(input int c, input logic v, input logic [63:0] o, input logic [31:0] a,
                        input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] rd, input logic [31:0] wd);
    valid[c] = v;
    order[c*64 +: 64] = o;
    addr[c*32 +: 32] = a;
    rmask[c*4 +: 4] = rm;
    wmask[c*4 +: 4] = wm;
    rdata[c*32 +: 32] = rd;
    wdata[c*32 +: 32] = wd;
  endtask

  // Applies the model to the current bus (optionally patching rdata with correct bytes), then clocks.
  task automatic step(input logic [1:0] fix);
    int unsigned n = 0;
    bit found = 0;
    int unsigned fc = 0, fb = 0;
    logic [63:0] fo = '0;
    for (int c = 0; c < 2; c++) begin
      if (valid[c]) begin
        logic [31:0] a;
        int unsigned m, base;
        a = addr[c*32 +: 32];
        m = mult(a);
        base = a & ~32'd3;
        if (m > 0) begin
          for (int i = 0; i < 4; i++) begin
            if (rmask[c*4+i] && m_mem.exists(base+i)) begin
              if (fix[c]) rdata[c*32+i*8 +: 8] = m_mem[base+i];
              n += m;
              if (!found && m_mem[base+i] != rdata[c*32+i*8 +: 8]) begin
                found = 1; fc = c; fb = i; fo = order[c*64 +: 64];
              end
            end
          end
          for (int i = 0; i < 4; i++)
            if (wmask[c*4+i]) m_mem[base+i] = wdata[c*32+i*8 +: 8];
        end
      end
    end
    m_cnt += n;
    if (found && !m_err) begin
      m_err = 1; m_order = fo; m_chan = fc; m_byte = fb;
    end
    @(posedge clk); #1;
    clear_bus();
  endtask

  task automatic pulse_reset();
    clear_bus();
    resetn = 1'b0;
    model_reset();
    #2;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b want=0", err); end
    checks++;
    if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d want=0", cnt); end
    checks++;
    if (err_order !== 64'd0 || err_chan !== 2'd0 || err_byte !== 3'd0) begin
      errors++; $display("FAIL reset_capture got=%0d/%0d/%0d want=0/0/0", err_order, err_chan, err_byte);
    end
    checks++;
  endtask

  task automatic test_write_read();
    pulse_reset();
    set_ch(0, 1, 64'd1, 32'h100, 4'h0, 4'hF, 32'h0, 32'hDEADBEEF);
    step(2'b00);
    set_ch(0, 1, 64'd2, 32'h100, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0);
    step(2'b00);
    if (err !== 1'b0) begin errors++; $display("FAIL wr_rd_err got=%0b want=0", err); end
    checks++;
    if (cnt !== 16'd4) begin errors++; $display("FAIL wr_rd_cnt got=%0d want=4", cnt); end
    checks++;
  endtask

  task automatic test_byte_mismatch();
    pulse_reset();
    set_ch(0, 1, 64'd3, 32'h100, 4'h0, 4'hF, 32'h0, 32'hDEADBEEF);
    step(2'b00);
    set_ch(0, 1, 64'd5, 32'h101, 4'h2, 4'h0, 32'h0000AA00, 32'h0);
    if (err !== 1'b0) begin errors++; $display("FAIL mm_pre_err got=%0b want=0", err); end
    checks++;
    step(2'b00);
    if (err !== 1'b1) begin errors++; $display("FAIL mm_err got=%0b want=1", err); end
    checks++;
    if (err_byte !== 3'd1) begin errors++; $display("FAIL mm_byte got=%0d want=1", err_byte); end
    checks++;
    if (err_order !== 64'd5) begin errors++; $display("FAIL mm_order got=%0d want=5", err_order); end
    checks++;
    if (err_chan !== 2'd0) begin errors++; $display("FAIL mm_chan got=%0d want=0", err_chan); end
    checks++;
  endtask

  task automatic test_same_cycle();
    pulse_reset();
    set_ch(0, 1, 64'd10, 32'h200, 4'h0, 4'h1, 32'h0, 32'h00000011);
    set_ch(1, 1, 64'd11, 32'h200, 4'h1, 4'h0, 32'h00000011, 32'h0);
    step(2'b00);
    if (err !== 1'b0 || cnt !== 16'd1) begin
      errors++; $display("FAIL chain_ok got=err%0b/cnt%0d want=err0/cnt1", err, cnt);
    end
    checks++;
    pulse_reset();
    set_ch(0, 1, 64'd10, 32'h200, 4'h0, 4'h1, 32'h0, 32'h00000011);
    set_ch(1, 1, 64'd11, 32'h200, 4'h1, 4'h0, 32'h00000022, 32'h0);
    step(2'b00);
    if (err !== 1'b1 || err_chan !== 2'd1) begin
      errors++; $display("FAIL chain_bad got=err%0b/chan%0d want=err1/chan1", err, err_chan);
    end
    checks++;
    if (err_order !== 64'd11 || err_byte !== 3'd0) begin
      errors++; $display("FAIL chain_bad_cap got=%0d/%0d want=11/0", err_order, err_byte);
    end
    checks++;
  endtask

  task automatic test_unwritten_and_reset();
    pulse_reset();
    set_ch(0, 1, 64'd20, 32'h300, 4'hF, 4'h0, $urandom, 32'h0);
    step(2'b00);
    if (err !== 1'b0 || cnt !== 16'd0) begin
      errors++; $display("FAIL unwritten got=err%0b/cnt%0d want=err0/cnt0", err, cnt);
    end
    checks++;
    set_ch(0, 1, 64'd21, 32'h303, 4'h0, 4'h8, 32'h0, 32'h5A000000);
    step(2'b00);
    pulse_reset();
    set_ch(0, 1, 64'd22, 32'h300, 4'hF, 4'h0, 32'h0, 32'h0);
    step(2'b00);
    if (err !== 1'b0 || cnt !== 16'd0) begin
      errors++; $display("FAIL post_reset got=err%0b/cnt%0d want=err0/cnt0", err, cnt);
    end
    checks++;
  endtask

  task automatic test_capture_and_sat();
    logic [31:0] w;
    w = $urandom;
    pulse_reset();
    set_ch(0, 1, 64'd1, 32'h300, 4'h0, 4'hF, 32'h0, w);
    step(2'b00);
    set_ch(0, 1, 64'd7, 32'h300, 4'hF, 4'h0, w ^ 32'h0000_0001, 32'h0);
    step(2'b00);
    set_ch(0, 1, 64'd9, 32'h300, 4'hF, 4'h0, w ^ 32'h0100_0000, 32'h0);
    step(2'b00);
    if (err_order !== 64'd7 || err_byte !== 3'd0) begin
      errors++; $display("FAIL first_capture got=%0d/%0d want=7/0", err_order, err_byte);
    end
    checks++;
    for (int k = 0; k < 3; k++) begin
      set_ch(0, 1, 64'(10 + k), 32'h300, 4'hF, 4'h0, w, 32'h0);
      step(2'b00);
    end
    if (cnt !== 16'd20) begin errors++; $display("FAIL cnt20 got=%0d want=20", cnt); end
    checks++;
    if (s_cnt !== 4'd15) begin errors++; $display("FAIL sat got=%0d want=15", s_cnt); end
    checks++;
    if (s_err !== 1'b1 || s_err_order !== 64'd7) begin
      errors++; $display("FAIL small_capture got=%0b/%0d want=1/7", s_err, s_err_order);
    end
    checks++;
  endtask

  task automatic test_random();
    int unsigned e16, e4;
    pulse_reset();
    for (int n = 0; n < 300; n++) begin
      logic [1:0] fix;
      for (int c = 0; c < 2; c++) begin
        int unsigned pick;
        logic [31:0] a;
        pick = $urandom_range(0, 4);
        a = (pick == 4) ? 32'h500 : tracked[pick];
        a = a | 32'($urandom_range(0, 3));
        set_ch(c, ($urandom_range(0, 3) != 0), 64'(n*2 + c), a,
               4'($urandom), 4'($urandom), $urandom, $urandom);
        fix[c] = ($urandom_range(0, 59) != 0);
      end
      step(fix);
      e16 = (m_cnt > 65535) ? 65535 : m_cnt;
      e4  = (m_cnt > 15) ? 15 : m_cnt;
      if (err !== m_err) begin errors++; $display("FAIL rnd_err cyc=%0d got=%0b want=%0b", n, err, m_err); end
      checks++;
      if (cnt !== 16'(e16) || s_cnt !== 4'(e4)) begin
        errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", n, cnt, s_cnt, e16, e4);
      end
      checks++;
      if (m_err) begin
        if (err_order !== m_order || err_chan !== 2'(m_chan) || err_byte !== 3'(m_byte)) begin
          errors++;
          $display("FAIL rnd_capture cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d",
                   n, err_order, err_chan, err_byte, m_order, m_chan, m_byte);
        end
        checks++;
      end
    end
  endtask

  initial begin
    clear_bus();
    model_reset();
    resetn = 1'b0;
    @(posedge clk); #1;
    test_reset();
    resetn = 1'b1;
    test_write_read();
    test_byte_mismatch();
    test_same_cycle();
    test_unwritten_and_reset();
    test_capture_and_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
